// File: rtl/bcd_conv_arbiter_if.sv
// Requester-side bundle for the shared BCD converter: level req plus packed binary values in, one-hot grant/done/result out.
// The master modport is the requester side; the slave modport is the converter side.
interface bcd_conv_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 6
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] bin_in;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic                  done;
  logic [2:0]            res_id;
  logic [3:0]            dig_tens;
  logic [3:0]            dig_ones;

  modport master (
    output req, bin_in,
    input  grant, busy, done, res_id, dig_tens, dig_ones
  );

  modport slave (
    input  req, bin_in,
    output grant, busy, done, res_id, dig_tens, dig_ones
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin shared shift-and-add-3 binary-to-BCD converter; done pulses WIDTH cycles after grant, one job per WIDTH+2 cycles.
// Losers simply keep req high and wait. BCD_CONV_CACHE_EN adds a per-requester result cache that answers repeat values in the grant cycle.
module bcd_conv_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  bcd_conv_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_ptr;
  logic [2:0]        r_win;
  logic [2:0]        r_cnt;
  logic [WIDTH-1:0]  r_bin;
  logic [7:0]        r_acc;
  logic [NREQ-1:0]   r_grant;
  logic              r_done;
  logic [2:0]        r_res_id;
  logic [3:0]        r_tens;
  logic [3:0]        r_ones;

  logic              w_any;
  logic [2:0]        w_win;
  logic [3:0]        w_dist;
  logic [3:0]        w_best;
  logic [2:0]        w_ptr_nxt;
  logic [WIDTH-1:0]  w_sel;
  logic [3:0]        w_adj_tens;
  logic [3:0]        w_adj_ones;
  logic [7:0]        w_acc_nxt;
  logic              w_last;
  logic              w_hit;

  // Winner is the requesting index with the smallest wrapped distance from r_ptr.
  always_comb begin
    w_any  = 1'b0;
    w_win  = 3'd0;
    w_dist = 4'd0;
    w_best = 4'd15;
    for (int i = 0; i < NREQ; i++) begin
      if (4'(i) >= {1'b0, r_ptr})
        w_dist = 4'(i) - {1'b0, r_ptr};
      else
        w_dist = 4'(i + NREQ) - {1'b0, r_ptr};
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_win  = 3'(i);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 3'(i))
        w_sel = bus.bin_in[i*WIDTH +: WIDTH];
    end
  end

  assign w_ptr_nxt  = (w_win == 3'(NREQ - 1)) ? 3'd0 : w_win + 3'd1;
  assign w_adj_tens = (r_acc[7:4] > 4'd4) ? r_acc[7:4] + 4'd3 : r_acc[7:4];
  assign w_adj_ones = (r_acc[3:0] > 4'd4) ? r_acc[3:0] + 4'd3 : r_acc[3:0];
  assign w_acc_nxt  = 8'({w_adj_tens, w_adj_ones, r_bin[WIDTH-1]});
  assign w_last     = (r_cnt == 3'(WIDTH - 1));

`ifdef BCD_CONV_CACHE_EN
  logic [WIDTH-1:0] r_bin_cap;
  logic [NREQ-1:0]  r_c_vld;
  logic [WIDTH-1:0] r_c_bin  [NREQ];
  logic [3:0]       r_c_tens [NREQ];
  logic [3:0]       r_c_ones [NREQ];
  logic [3:0]       w_c_tens;
  logic [3:0]       w_c_ones;

  always_comb begin
    w_hit    = 1'b0;
    w_c_tens = 4'd0;
    w_c_ones = 4'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == 3'(i)) begin
        w_hit    = r_c_vld[i] && (r_c_bin[i] == w_sel);
        w_c_tens = r_c_tens[i];
        w_c_ones = r_c_ones[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bin_cap <= '0;
      r_c_vld   <= '0;
      for (int i = 0; i < NREQ; i++) begin
        r_c_bin[i]  <= '0;
        r_c_tens[i] <= 4'd0;
        r_c_ones[i] <= 4'd0;
      end
    end else begin
      if (r_state == S_IDLE && w_any)
        r_bin_cap <= w_sel;
      // Only a completed conversion refreshes the entry; aborted jobs never reach here.
      if (r_state == S_SHIFT && w_last) begin
        for (int i = 0; i < NREQ; i++) begin
          if (r_win == 3'(i)) begin
            r_c_vld[i]  <= 1'b1;
            r_c_bin[i]  <= r_bin_cap;
            r_c_tens[i] <= w_acc_nxt[7:4];
            r_c_ones[i] <= w_acc_nxt[3:0];
          end
        end
      end
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = w_hit ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= 3'd0;
      r_win    <= 3'd0;
      r_cnt    <= 3'd0;
      r_bin    <= '0;
      r_acc    <= 8'd0;
      r_grant  <= '0;
      r_done   <= 1'b0;
      r_res_id <= 3'd0;
      r_tens   <= 4'd0;
      r_ones   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= NREQ'(1) << w_win;
            r_win   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_bin   <= w_sel;
            r_acc   <= 8'd0;
            r_cnt   <= 3'd0;
`ifdef BCD_CONV_CACHE_EN
            if (w_hit) begin
              r_done   <= 1'b1;
              r_tens   <= w_c_tens;
              r_ones   <= w_c_ones;
              r_res_id <= w_win;
            end
`endif
          end
        end
        S_SHIFT: begin
          r_acc <= w_acc_nxt;
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 3'd1;
          if (w_last) begin
            r_done   <= 1'b1;
            r_tens   <= w_acc_nxt[7:4];
            r_ones   <= w_acc_nxt[3:0];
            r_res_id <= r_win;
          end
        end
        S_DONE: begin
          r_grant <= '0;
          r_done  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = r_done;
  assign bus.res_id   = r_res_id;
  assign bus.dig_tens = r_tens;
  assign bus.dig_ones = r_ones;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter (NREQ=2, WIDTH=6); define BCD_CONV_CACHE_EN on both RTL and bench to cover the cache.
module tb_bcd_conv_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   done_seen;
  int   onehot_viol;
  int   n;
  int   ds;

  bcd_conv_arbiter_if #(.NREQ(2), .WIDTH(6)) bus ();

  bcd_conv_arbiter #(.NREQ(2), .WIDTH(6)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done) done_seen++;
    if ($countones(bus.grant) > 1) onehot_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_bin(input int i, input logic [5:0] v);
    if (i == 0) bus.bin_in[5:0] = v;
    else        bus.bin_in[11:6] = v;
  endtask

  // Cycles from now until done is seen (bounded).
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!bus.done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Cycles from the current done to the next one (bounded).
  task automatic wait_gap(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!bus.done && cycles < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; done_seen = 0; onehot_viol = 0;
    rst = 1'b1;
    bus.req = 2'b00;
    bus.bin_in = 12'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_tens", bus.dig_tens, 0);
    chk("rst_ones", bus.dig_ones, 0);

    // Single conversion of 47
    set_bin(0, 6'd47); bus.req = 2'b01;
    @(negedge clk);
    chk("t1_grant", bus.grant, 2'b01);
    chk("t1_busy", bus.busy, 1);
    wait_done(n);
    chk("t1_latency", n, 6);
    chk("t1_tens", bus.dig_tens, 4);
    chk("t1_ones", bus.dig_ones, 7);
    chk("t1_res_id", bus.res_id, 0);
    chk("t1_grant_in_done", bus.grant, 2'b01);
    bus.req = 2'b00;
    @(negedge clk);
    chk("t1_done_pulse", bus.done, 0);
    chk("t1_busy_low", bus.busy, 0);
    chk("t1_grant_clr", bus.grant, 0);
    chk("t1_tens_hold", bus.dig_tens, 4);

    // Back-to-back 0, 63, 9 with req held
    set_bin(0, 6'd0); bus.req = 2'b01;
    @(negedge clk);
    wait_done(n);
    chk("t2_lat0", n, 6);
    chk("t2_tens0", bus.dig_tens, 0);
    chk("t2_ones0", bus.dig_ones, 0);
    set_bin(0, 6'd63);
    wait_gap(n);
    chk("t2_gap63", n, 8);
    chk("t2_tens63", bus.dig_tens, 6);
    chk("t2_ones63", bus.dig_ones, 3);
    set_bin(0, 6'd9);
    wait_gap(n);
    chk("t2_gap9", n, 8);
    chk("t2_tens9", bus.dig_tens, 0);
    chk("t2_ones9", bus.dig_ones, 9);
    bus.req = 2'b00;
    @(negedge clk);

    // Two requesters held: 0, 1, 0 from a fresh pointer
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    set_bin(0, 6'd12); set_bin(1, 6'd35); bus.req = 2'b11;
    @(negedge clk);
    chk("t3_grant_a", bus.grant, 2'b01);
    wait_done(n);
    chk("t3_lat_a", n, 6);
    chk("t3_id_a", bus.res_id, 0);
    chk("t3_tens_a", bus.dig_tens, 1);
    chk("t3_ones_a", bus.dig_ones, 2);
    set_bin(0, 6'd40);
    wait_gap(n);
    chk("t3_gap_b", n, 8);
    chk("t3_id_b", bus.res_id, 1);
    chk("t3_grant_b", bus.grant, 2'b10);
    chk("t3_tens_b", bus.dig_tens, 3);
    chk("t3_ones_b", bus.dig_ones, 5);
    wait_gap(n);
    chk("t3_gap_c", n, 8);
    chk("t3_id_c", bus.res_id, 0);
    chk("t3_tens_c", bus.dig_tens, 4);
    chk("t3_ones_c", bus.dig_ones, 0);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    // req dropped right after grant still completes
    set_bin(0, 6'd33); bus.req = 2'b01;
    @(negedge clk);
    chk("t4_grant", bus.grant, 2'b01);
    bus.req = 2'b00;
    wait_done(n);
    chk("t4_lat", n, 6);
    chk("t4_tens", bus.dig_tens, 3);
    chk("t4_ones", bus.dig_ones, 3);
    @(negedge clk);
    // Glitch between edges while idle is never sampled
    bus.req = 2'b10; #2; bus.req = 2'b00;
    repeat (3) @(negedge clk);
    chk("t4_glitch_busy", bus.busy, 0);
    chk("t4_glitch_grant", bus.grant, 0);
    // Pulse from requester 1 during SHIFT is ignored
    set_bin(0, 6'd5); bus.req = 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    @(negedge clk);
    bus.req = 2'b10;
    @(negedge clk);
    bus.req = 2'b00;
    wait_done(n);
    chk("t4_shift_lat", n, 4);
    chk("t4_shift_ones", bus.dig_ones, 5);
    repeat (3) @(negedge clk);
    chk("t4_shift_busy", bus.busy, 0);

    // Reset in the third SHIFT cycle
    set_bin(0, 6'd20); bus.req = 2'b01;
    repeat (3) @(negedge clk);
    chk("t5_busy_pre", bus.busy, 1);
    ds = done_seen;
    rst = 1'b1;
    #1;
    chk("t5_grant", bus.grant, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_done", bus.done, 0);
    chk("t5_ones", bus.dig_ones, 0);
    chk("t5_res_id", bus.res_id, 0);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_no_done", done_seen, ds);
    set_bin(0, 6'd58); bus.req = 2'b01;
    @(negedge clk);
    wait_done(n);
    chk("t5_lat", n, 6);
    chk("t5_tens", bus.dig_tens, 5);
    chk("t5_ones", bus.dig_ones, 8);
    bus.req = 2'b00;
    @(negedge clk);

    // Requester 1 repeats 21, then 22
    set_bin(1, 6'd21); bus.req = 2'b10;
    @(negedge clk);
    chk("t6_grant1", bus.grant, 2'b10);
    wait_done(n);
    chk("t6_lat1", n, 6);
    chk("t6_id1", bus.res_id, 1);
    chk("t6_tens1", bus.dig_tens, 2);
    chk("t6_ones1", bus.dig_ones, 1);
    bus.req = 2'b00;
    @(negedge clk);
    bus.req = 2'b10;
    @(negedge clk);
    chk("t6_grant2", bus.grant, 2'b10);
    wait_done(n);
`ifdef BCD_CONV_CACHE_EN
    chk("t6_lat2", n, 0);
`else
    chk("t6_lat2", n, 6);
`endif
    chk("t6_tens2", bus.dig_tens, 2);
    chk("t6_ones2", bus.dig_ones, 1);
    chk("t6_id2", bus.res_id, 1);
    bus.req = 2'b00;
    @(negedge clk);
    chk("t6_idle2", bus.busy, 0);
    set_bin(1, 6'd22); bus.req = 2'b10;
    @(negedge clk);
    wait_done(n);
    chk("t6_lat3", n, 6);
    chk("t6_tens3", bus.dig_tens, 2);
    chk("t6_ones3", bus.dig_ones, 2);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);

    chk("grant_onehot", onehot_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
